// File: rtl/sweep_marker_sched.sv
// Sweep marker scheduler: steps through a small marker table and loads each marker
// downstream. Pulses Marker_Hit when the sweep position reaches the armed marker.
module sweep_marker_sched #(
    parameter int NMARK = 4,
    parameter int W     = 12
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Cfg_WE,
    input  logic [1:0]   Cfg_Addr,
    input  logic [W-1:0] Cfg_Data,
    input  logic [2:0]   Cfg_Count,
    input  logic         Sweep_Start,
    input  logic         Sweep_Abort,
    input  logic         Sweep_Step,
    input  logic [W-1:0] Sweep_Pos,
    output logic [W-1:0] LD_Din,
    output logic         LD_EN,
    output logic         Marker_Hit,
    output logic [1:0]   Marker_Idx,
    output logic         Busy,
    output logic         Done,
    output logic         Cfg_Err
);

    typedef enum logic [2:0] {IDLE, LOAD, ARMED, HIT, DONE} state_t;

    state_t       state;
    logic [W-1:0] mark_tab [NMARK];
    logic [2:0]   count_q;
    logic [1:0]   idx;
    logic [2:0]   eff_count;
    logic         last_mark;

    // NOTE: continuous assigns cannot infer latches; any always_comb here would need a default first.
    assign eff_count = (Cfg_Count > 3'(NMARK)) ? 3'(NMARK) : Cfg_Count;
    assign last_mark = ({1'b0, idx} == (count_q - 3'd1));

    // NOTE: the table is reset explicitly because a cleared table after reset is part of the contract;
    // plain storage arrays would normally be left unreset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NMARK; i++) mark_tab[i] <= '0;
        end else if (Cfg_WE && state == IDLE) begin
            mark_tab[Cfg_Addr] <= Cfg_Data;
        end
    end

    // NOTE: all state and outputs use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            count_q    <= '0;
            idx        <= '0;
            LD_Din     <= '0;
            LD_EN      <= 1'b0;
            Marker_Hit <= 1'b0;
            Marker_Idx <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Cfg_Err    <= 1'b0;
        end else begin
            LD_EN      <= 1'b0;
            Marker_Hit <= 1'b0;
            Done       <= 1'b0;
            Cfg_Err    <= Cfg_WE && (state != IDLE);

            // Abort wins over every other event once a sequence is running.
            if (Sweep_Abort && state != IDLE) begin
                state <= IDLE;
                Busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (Sweep_Start) begin
                            count_q <= eff_count;
                            idx     <= '0;
                            Busy    <= 1'b1;
                            if (eff_count == 3'd0) begin
                                state <= DONE;
                            end else begin
                                state      <= LOAD;
                                LD_EN      <= 1'b1;
                                LD_Din     <= mark_tab[0];
                                Marker_Idx <= '0;
                            end
                        end
                    end
                    LOAD: state <= ARMED;
                    ARMED: begin
                        if (Sweep_Step && Sweep_Pos >= LD_Din) begin
                            state      <= HIT;
                            Marker_Hit <= 1'b1;
                            Marker_Idx <= idx;
                        end
                    end
                    HIT: begin
                        if (last_mark) begin
                            state <= DONE;
                        end else begin
                            state      <= LOAD;
                            idx        <= idx + 2'd1;
                            LD_EN      <= 1'b1;
                            LD_Din     <= mark_tab[idx + 2'd1];
                            Marker_Idx <= idx + 2'd1;
                        end
                    end
                    DONE: begin
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sweep_marker_sched.sv
// Self-checking bench for sweep_marker_sched: directed scenarios plus randomized sequences
// checked against an event-level marker model.
module tb_sweep_marker_sched;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Cfg_WE = 1'b0;
    logic [1:0]  Cfg_Addr = '0;
    logic [11:0] Cfg_Data = '0;
    logic [2:0]  Cfg_Count = '0;
    logic        Sweep_Start = 1'b0;
    logic        Sweep_Abort = 1'b0;
    logic        Sweep_Step = 1'b0;
    logic [11:0] Sweep_Pos = '0;
    logic [11:0] LD_Din;
    logic        LD_EN;
    logic        Marker_Hit;
    logic [1:0]  Marker_Idx;
    logic        Busy;
    logic        Done;
    logic        Cfg_Err;

    sweep_marker_sched #(.NMARK(4), .W(12)) dut (
        .Clock(Clock), .Reset(Reset),
        .Cfg_WE(Cfg_WE), .Cfg_Addr(Cfg_Addr), .Cfg_Data(Cfg_Data), .Cfg_Count(Cfg_Count),
        .Sweep_Start(Sweep_Start), .Sweep_Abort(Sweep_Abort), .Sweep_Step(Sweep_Step),
        .Sweep_Pos(Sweep_Pos), .LD_Din(LD_Din), .LD_EN(LD_EN), .Marker_Hit(Marker_Hit),
        .Marker_Idx(Marker_Idx), .Busy(Busy), .Done(Done), .Cfg_Err(Cfg_Err)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] mdl_tab [4];
    logic [11:0] step_q [$];
    logic [11:0] cur_pos = '0;

    // Event monitor: records what the DUT emitted while a sequence runs.
    logic        mon_en = 1'b0;
    logic [11:0] got_loads [$];
    logic [13:0] got_hits [$];
    int          got_done = 0;

    always @(negedge Clock) begin
        if (mon_en) begin
            if (LD_EN) got_loads.push_back(LD_Din);
            if (Marker_Hit) got_hits.push_back({Marker_Idx, cur_pos});
            if (Done) got_done++;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic write_tab(input logic [1:0] a, input logic [11:0] d);
        Cfg_WE = 1'b1; Cfg_Addr = a; Cfg_Data = d;
        tick();
        Cfg_WE = 1'b0;
        mdl_tab[a] = d;
    endtask

    task automatic load_default_table();
        write_tab(2'd0, 12'h100);
        write_tab(2'd1, 12'h200);
        write_tab(2'd2, 12'h300);
        write_tab(2'd3, 12'h400);
    endtask

    // Steps are spaced four cycles apart so each one lands while a marker is armed.
    task automatic do_step(input logic [11:0] p);
        Sweep_Step = 1'b1; Sweep_Pos = p; cur_pos = p;
        tick();
        Sweep_Step = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pulse_abort();
        Sweep_Abort = 1'b1;
        tick();
        Sweep_Abort = 1'b0;
    endtask

    // Runs one sequence with the steps in step_q and compares emitted events to the model.
    task automatic run_seq(input logic [2:0] cnt, input string name);
        int          n;
        int          k;
        int          exp_done;
        logic [11:0] exp_loads [$];
        logic [13:0] exp_hits [$];

        n = (cnt > 3'd4) ? 4 : int'(cnt);
        k = 0;
        if (n > 0) exp_loads.push_back(mdl_tab[0]);
        foreach (step_q[i]) begin
            if (k < n && step_q[i] >= mdl_tab[k]) begin
                exp_hits.push_back({2'(k), step_q[i]});
                k++;
                if (k < n) exp_loads.push_back(mdl_tab[k]);
            end
        end
        exp_done = (k == n) ? 1 : 0;

        got_loads.delete();
        got_hits.delete();
        got_done = 0;
        mon_en = 1'b1;
        Cfg_Count = cnt;
        Sweep_Start = 1'b1;
        tick();
        Sweep_Start = 1'b0;
        tick();
        foreach (step_q[i]) do_step(step_q[i]);
        repeat (3) tick();
        if (exp_done == 0) pulse_abort();
        repeat (2) tick();
        mon_en = 1'b0;

        n_checks++;
        if (got_loads.size() !== exp_loads.size()) begin
            n_fail++;
            $display("FAIL %s load_count: got %0d expected %0d", name, got_loads.size(), exp_loads.size());
        end
        for (int i = 0; i < exp_loads.size() && i < got_loads.size(); i++) begin
            n_checks++;
            if (got_loads[i] !== exp_loads[i]) begin
                n_fail++;
                $display("FAIL %s load[%0d]: got %h expected %h", name, i, got_loads[i], exp_loads[i]);
            end
        end
        n_checks++;
        if (got_hits.size() !== exp_hits.size()) begin
            n_fail++;
            $display("FAIL %s hit_count: got %0d expected %0d", name, got_hits.size(), exp_hits.size());
        end
        for (int i = 0; i < exp_hits.size() && i < got_hits.size(); i++) begin
            n_checks++;
            if (got_hits[i] !== exp_hits[i]) begin
                n_fail++;
                $display("FAIL %s hit[%0d] {idx,pos}: got %h expected %h", name, i, got_hits[i], exp_hits[i]);
            end
        end
        n_checks++;
        if (got_done !== exp_done) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d expected %0d", name, got_done, exp_done);
        end
        n_checks++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_after: got %b expected 0", name, Busy);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({LD_Din, LD_EN, Marker_Hit, Marker_Idx, Busy, Done, Cfg_Err} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {LD_Din, LD_EN, Marker_Hit, Marker_Idx, Busy, Done, Cfg_Err});
        end
        for (int i = 0; i < 4; i++) mdl_tab[i] = '0;
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        load_default_table();
        step_q.delete();
        for (int p = 0; p <= 12'h400; p += 12'h40) step_q.push_back(12'(p));
        run_seq(3'd4, "basic");
    endtask

    task automatic test_latency();
        Cfg_Count = 3'd4;
        Sweep_Start = 1'b1;
        tick();
        Sweep_Start = 1'b0;
        n_checks++;
        if ({LD_EN, LD_Din, Busy} !== {1'b1, 12'h100, 1'b1}) begin
            n_fail++;
            $display("FAIL start_latency {en,din,busy}: got %h expected %h", {LD_EN, LD_Din, Busy}, {1'b1, 12'h100, 1'b1});
        end
        Sweep_Start = 1'b1;
        tick();
        Sweep_Start = 1'b0;
        n_checks++;
        if ({LD_EN, LD_Din} !== {1'b0, 12'h100}) begin
            n_fail++;
            $display("FAIL hold_and_ignore_start {en,din}: got %h expected %h", {LD_EN, LD_Din}, {1'b0, 12'h100});
        end
        tick();
        n_checks++;
        if (LD_EN !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_ignored ld_en: got %b expected 0", LD_EN);
        end
        Sweep_Step = 1'b1; Sweep_Pos = 12'h0FF;
        tick();
        Sweep_Step = 1'b0;
        n_checks++;
        if (Marker_Hit !== 1'b0) begin
            n_fail++;
            $display("FAIL below_marker hit: got %b expected 0", Marker_Hit);
        end
        Sweep_Step = 1'b1; Sweep_Pos = 12'h100;
        tick();
        Sweep_Step = 1'b0;
        n_checks++;
        if ({Marker_Hit, Marker_Idx} !== 3'b100) begin
            n_fail++;
            $display("FAIL hit_latency {hit,idx}: got %b expected 100", {Marker_Hit, Marker_Idx});
        end
        tick();
        n_checks++;
        if ({Marker_Hit, LD_EN, LD_Din, Marker_Idx} !== {1'b0, 1'b1, 12'h200, 2'd1}) begin
            n_fail++;
            $display("FAIL second_load {hit,en,din,idx}: got %h expected %h",
                     {Marker_Hit, LD_EN, LD_Din, Marker_Idx}, {1'b0, 1'b1, 12'h200, 2'd1});
        end
        pulse_abort();
        tick();
    endtask

    task automatic test_count_zero();
        bit saw_bad;
        saw_bad = 1'b0;
        Cfg_Count = 3'd0;
        Sweep_Start = 1'b1;
        tick();
        Sweep_Start = 1'b0;
        n_checks++;
        if ({Done, Busy, LD_EN} !== 3'b010) begin
            n_fail++;
            $display("FAIL count0_t1 {done,busy,en}: got %b expected 010", {Done, Busy, LD_EN});
        end
        tick();
        n_checks++;
        if ({Done, Busy, LD_EN, Marker_Hit} !== 4'b1000) begin
            n_fail++;
            $display("FAIL count0_t2 {done,busy,en,hit}: got %b expected 1000", {Done, Busy, LD_EN, Marker_Hit});
        end
        repeat (3) begin
            tick();
            if (Done || LD_EN || Marker_Hit) saw_bad = 1'b1;
        end
        n_checks++;
        if (saw_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL count0_quiet: got activity=%b expected 0", saw_bad);
        end
    endtask

    task automatic test_count_clamp();
        step_q.delete();
        for (int p = 0; p <= 12'h400; p += 12'h80) step_q.push_back(12'(p));
        run_seq(3'd7, "count7");
    endtask

    task automatic test_cfg_err();
        Cfg_Count = 3'd4;
        Sweep_Start = 1'b1;
        tick();
        Sweep_Start = 1'b0;
        tick();
        Cfg_WE = 1'b1; Cfg_Addr = 2'd1; Cfg_Data = 12'hABC;
        tick();
        Cfg_WE = 1'b0;
        n_checks++;
        if (Cfg_Err !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_err_pulse: got %b expected 1", Cfg_Err);
        end
        tick();
        n_checks++;
        if (Cfg_Err !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_single: got %b expected 0", Cfg_Err);
        end
        pulse_abort();
        tick();
        step_q.delete();
        for (int p = 0; p <= 12'h400; p += 12'h100) step_q.push_back(12'(p));
        run_seq(3'd4, "after_cfg_err");
    endtask

    task automatic test_abort_vs_hit();
        bit saw_done;
        saw_done = 1'b0;
        Cfg_Count = 3'd4;
        Sweep_Start = 1'b1;
        tick();
        Sweep_Start = 1'b0;
        tick();
        Sweep_Step = 1'b1; Sweep_Pos = 12'h150; Sweep_Abort = 1'b1;
        tick();
        Sweep_Step = 1'b0; Sweep_Abort = 1'b0;
        n_checks++;
        if ({Marker_Hit, Busy, LD_EN, Done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_priority {hit,busy,en,done}: got %b expected 0000", {Marker_Hit, Busy, LD_EN, Done});
        end
        repeat (4) begin
            tick();
            if (Done || Marker_Hit || LD_EN || Busy) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_stays_idle: got activity=%b expected 0", saw_done);
        end
    endtask

    task automatic test_unsorted();
        write_tab(2'd0, 12'h300);
        write_tab(2'd1, 12'h050);
        write_tab(2'd2, 12'h3FF);
        write_tab(2'd3, 12'h010);
        step_q = '{12'h100, 12'h300, 12'h300, 12'h200, 12'h400, 12'h000};
        run_seq(3'd4, "unsorted");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < 4; a++) write_tab(2'(a), 12'($urandom_range(0, 4095)));
            step_q.delete();
            for (int s = 0; s < 10; s++) step_q.push_back(12'($urandom_range(0, 4095)));
            run_seq(3'($urandom_range(0, 7)), $sformatf("random%0d", it));
        end
    endtask

    task automatic test_async_reset();
        load_default_table();
        Cfg_Count = 3'd4;
        Sweep_Start = 1'b1;
        tick();
        Sweep_Start = 1'b0;
        tick();
        #2;
        Reset = 1'b0;
        #1;
        n_checks++;
        if ({LD_Din, LD_EN, Marker_Hit, Marker_Idx, Busy, Done, Cfg_Err} !== 19'd0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %h expected 0",
                     {LD_Din, LD_EN, Marker_Hit, Marker_Idx, Busy, Done, Cfg_Err});
        end
        for (int i = 0; i < 4; i++) mdl_tab[i] = '0;
        tick();
        Reset = 1'b1;
        tick();
        step_q = '{12'h050, 12'h000, 12'h7FF, 12'h001};
        run_seq(3'd4, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_count_zero();
        test_count_clamp();
        test_cfg_err();
        test_abort_vs_hit();
        test_unsorted();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sweep_marker_sched.md
SWEEP_MARKER_SCHED -- requirements
Module: sweep_marker_sched

Interface
REQ-001 SHALL have parameter NMARK, default 4, meaning number of marker table entries (fixed at 4 in this revision).
REQ-002 SHALL have parameter W, default 12, meaning marker/sweep-position width.
REQ-003 Clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Cfg_WE  input  1  marker table write strobe.
REQ-006 Cfg_Addr  input  2  marker table entry index.
REQ-007 Cfg_Data  input  12  marker value to store.
REQ-008 Cfg_Count  input  3  number of active markers; legal range 0..4.
REQ-009 Sweep_Start  input  1  single-cycle pulse that starts a marker sequence.
REQ-010 Sweep_Abort  input  1  single-cycle pulse that terminates the sequence.
REQ-011 Sweep_Step  input  1  single-cycle pulse marking each sweep-position advance.
REQ-012 Sweep_Pos  input  12  current sweep position, valid when Sweep_Step=1.
REQ-013 LD_Din  output  12  value for the downstream marker value register.
REQ-014 LD_EN  output  1  load enable for the downstream marker value register.
REQ-015 Marker_Hit  output  1  one-cycle pulse when the armed marker is reached.
REQ-016 Marker_Idx  output  2  index of the currently loaded or armed marker.
REQ-017 Busy  output  1  high from the first cycle after start until return to IDLE.
REQ-018 Done  output  1  one-cycle pulse when the sequence completes normally.
REQ-019 Cfg_Err  output  1  one-cycle pulse when a table write is rejected.

Function
REQ-020 SHALL hold a 4x12 marker table, written on Cfg_WE only while in IDLE.
REQ-021 SHALL ignore Cfg_WE outside IDLE, keep the table unchanged, and pulse Cfg_Err the next cycle.
REQ-022 SHALL implement states IDLE, LOAD, ARMED, HIT, DONE; all outputs registered.
REQ-023 IDLE: on Sweep_Start, SHALL latch effective count N = min(Cfg_Count,4), set idx=0; go to DONE if N=0, else go to LOAD.
REQ-024 LOAD: SHALL assert LD_EN=1 with LD_Din=table[idx] for exactly one cycle, then go to ARMED.
REQ-025 ARMED: on Sweep_Step with Sweep_Pos >= LD_Din (unsigned compare), SHALL go to HIT; otherwise remain in ARMED.
REQ-026 HIT: SHALL pulse Marker_Hit for one cycle with Marker_Idx=idx; if idx=N-1 go to DONE, else increment idx and go to LOAD.
REQ-027 DONE: SHALL pulse Done for one cycle, then go to IDLE.
REQ-028 Latency: Sweep_Start in cycle t -> LD_EN high in cycle t+1; qualifying Sweep_Step in cycle t -> Marker_Hit high in cycle t+1.
REQ-029 Sweep_Abort in any non-IDLE state SHALL force IDLE next cycle with no Done pulse and LD_EN=0; Abort takes priority over Step, Start and hit.
REQ-030 Sweep_Start outside IDLE SHALL be ignored.
REQ-031 Markers are not required to be sorted; a marker at or below the current position SHALL be hit on the first Sweep_Step after arming.
REQ-032 LD_Din SHALL retain the last loaded value outside LOAD; LD_EN SHALL be 0 outside LOAD.
REQ-033 Busy SHALL be 1 in LOAD, ARMED, HIT and DONE, and 0 in IDLE.
REQ-034 Table contents SHALL persist across sequences and across Sweep_Abort.

Reset
REQ-035 Reset=0 SHALL immediately force IDLE, idx=0, LD_Din=0, LD_EN=0, Marker_Hit=0, Marker_Idx=0, Busy=0, Done=0, Cfg_Err=0, and clear all table entries to 0.
REQ-036 Reset asserted mid-sequence SHALL abort with no Done pulse; after release, the block SHALL wait in IDLE for Sweep_Start.

Verification
REQ-037 Write table {0x100,0x200,0x300,0x400}, Count=4, Start, step Pos 0..0x400 -> four LD_EN pulses with LD_Din 0x100..0x400, Marker_Hit at Pos 0x100/0x200/0x300/0x400 with Idx 0..3, then Done once.
REQ-038 Count=0, Start -> Done pulse at t+2, no LD_EN, no Marker_Hit.
REQ-039 Count=7, table as in REQ-037 -> behaves as Count=4 (four hits, then Done).
REQ-040 Cfg_WE to Addr 1 with Data 0xABC while ARMED -> Cfg_Err pulse; entry 1 still reads back 0x200 on the next sequence.
REQ-041 Sweep_Abort in the same cycle as a qualifying Step -> no Marker_Hit, IDLE next cycle, Busy=0, no Done.
REQ-042 Reset pulled low asynchronously in ARMED -> all outputs 0 before the next Clock edge; table reads 0 on the next sequence.
